x2050psw_store: RTL and testbench

- Reads back the condition code and program mask held by the CC/program-mask register block and streams the current PSW onto the W-bus, one byte per ROS advance. Used for the interrupt old-PSW store and for SPM/BAL-style reads.
- Also provides a BC-mode branch-condition test against the live CC.
- Sits beside the CC register, between ROS control and the local-storage/W-bus path.

---
 rtl/x2050psw_store_pkg.sv | 28 ++
 rtl/x2050psw_store_if.sv | 36 +++
 rtl/x2050psw_pack.sv | 32 +++
 rtl/x2050psw_store.sv | 99 +++++++++
 tb/tb_x2050psw_store.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/x2050psw_store_pkg.sv
// Shared PSW-store definitions: sequencer states and PSW byte offsets,
// so the CC writer, PSW packer and local-storage store path agree.
package x2050psw_store_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int BYTE_SYSMASK = 0;
   localparam int BYTE_KEYAMWP = 1;
   localparam int BYTE_INTHI   = 2;
   localparam int BYTE_INTLO   = 3;
   localparam int BYTE_CCPM    = 4;
   localparam int BYTE_IA_HI   = 5;
   localparam int BYTE_IA_MID  = 6;
   localparam int BYTE_IA_LO   = 7;

   // Byte 0 sits in the most significant position of the PSW doubleword.
   function automatic logic [7:0] psw_byte(
      input logic [63:0] psw,
      input logic [2:0]  idx
   );
      return psw[{~idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/x2050psw_store_if.sv
// ROS-side request/strobe and W-bus byte stream of the PSW store.
// master = ROS control / W-bus consumer, slave = PSW store unit.
interface x2050psw_store_if;

   logic       i_ros_advance;
   logic       i_start;
   logic       i_abort;
   logic [7:0] o_byte;
   logic [2:0] o_byte_idx;
   logic       o_valid;
   logic       o_busy;
   logic       o_done;

   modport master (
      output i_ros_advance,
      output i_start,
      output i_abort,
      input  o_byte,
      input  o_byte_idx,
      input  o_valid,
      input  o_busy,
      input  o_done
   );

   modport slave (
      input  i_ros_advance,
      input  i_start,
      input  i_abort,
      output o_byte,
      output o_byte_idx,
      output o_valid,
      output o_busy,
      output o_done
   );

endinterface

// File: rtl/x2050psw_pack.sv
// Combinational assembly of the 64-bit BC-mode PSW from its fields.
// Also used by the LPSW checker, so byte placement follows the package.
module x2050psw_pack
   import x2050psw_store_pkg::*;
(
   input  logic [7:0]  sysmask,
   input  logic [3:0]  key,
   input  logic [3:0]  amwp,
   input  logic [15:0] intcode,
   input  logic [1:0]  ilc,
   input  logic [1:0]  cc,
   input  logic [3:0]  progmask,
   input  logic [23:0] ia,
   output logic [63:0] psw
);

   logic [7:0] b [8];

   // Place each field at its byte offset, then flatten byte 0 first.
   always_comb begin
      b[BYTE_SYSMASK] = sysmask;
      b[BYTE_KEYAMWP] = {key, amwp};
      b[BYTE_INTHI]   = intcode[15:8];
      b[BYTE_INTLO]   = intcode[7:0];
      b[BYTE_CCPM]    = {ilc, cc, progmask};
      b[BYTE_IA_HI]   = ia[23:16];
      b[BYTE_IA_MID]  = ia[15:8];
      b[BYTE_IA_LO]   = ia[7:0];
      psw = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
   end

endmodule

// File: rtl/x2050psw_store.sv
// PSW store sequencer: snapshots the PSW on request and streams it
// onto the W-bus one byte per ROS advance; also tests BC conditions.
module x2050psw_store
   import x2050psw_store_pkg::*;
#(
   parameter int NBYTES = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   x2050psw_store_if.slave       bus,
   input  logic [1:0]            i_cc_reg,
   input  logic [3:0]            i_progmask,
   input  logic [1:0]            i_ilc,
   input  logic [7:0]            i_sysmask,
   input  logic [3:0]            i_key,
   input  logic [3:0]            i_amwp,
   input  logic [15:0]           i_intcode,
   input  logic [23:0]           i_ia,
   input  logic [3:0]            i_bc_mask,
   output logic                  o_bc_taken
);

   localparam logic [2:0] LAST = 3'(NBYTES - 1);

   state_t      state;
   logic [63:0] snap;
   logic [63:0] psw_live;

   x2050psw_pack u_pack (
      .sysmask  (i_sysmask),
      .key      (i_key),
      .amwp     (i_amwp),
      .intcode  (i_intcode),
      .ilc      (i_ilc),
      .cc       (i_cc_reg),
      .progmask (i_progmask),
      .ia       (i_ia),
      .psw      (psw_live)
   );

   // Mask bit 3 tests CC0, so the selected bit is 3-cc, i.e. ~cc.
   assign o_bc_taken = i_bc_mask[~i_cc_reg];

   // Store sequencer; every register holds unless the ROS advances.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state          <= ST_IDLE;
         snap           <= '0;
         bus.o_byte     <= '0;
         bus.o_byte_idx <= '0;
         bus.o_valid    <= 1'b0;
         bus.o_busy     <= 1'b0;
         bus.o_done     <= 1'b0;
      end else if (bus.i_ros_advance) begin
         unique case (state)
            ST_IDLE: begin
               if (bus.i_start && !bus.i_abort) begin
                  state          <= ST_SEND;
                  snap           <= psw_live;
                  bus.o_byte     <= psw_byte(psw_live, 3'd0);
                  bus.o_byte_idx <= 3'd0;
                  bus.o_valid    <= 1'b1;
                  bus.o_busy     <= 1'b1;
               end
            end
            ST_SEND: begin
               if (bus.i_abort) begin
                  state          <= ST_IDLE;
                  bus.o_byte_idx <= 3'd0;
                  bus.o_valid    <= 1'b0;
                  bus.o_busy     <= 1'b0;
                  bus.o_done     <= 1'b0;
               end else if (bus.o_byte_idx != LAST) begin
                  bus.o_byte_idx <= bus.o_byte_idx + 3'd1;
                  bus.o_byte     <= psw_byte(snap,
                                       bus.o_byte_idx + 3'd1);
               end else begin
                  state       <= ST_DONE;
                  bus.o_valid <= 1'b0;
                  bus.o_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state       <= ST_IDLE;
               bus.o_valid <= 1'b0;
               bus.o_busy  <= 1'b0;
               bus.o_done  <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               bus.o_valid <= 1'b0;
               bus.o_busy  <= 1'b0;
               bus.o_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_x2050psw_store.sv
// Directed bench for the PSW store: 8-byte and 4-byte builds side by
// side, sharing clock, reset, ROS advance and PSW fields.
module tb_x2050psw_store;

   logic        clk;
   logic        rst;
   logic        adv;
   logic        start8, abort8, start4, abort4;
   logic [1:0]  cc, ilc;
   logic [3:0]  pm, key, amwp, bcm;
   logic [7:0]  sysmask;
   logic [15:0] intcode;
   logic [23:0] ia;
   logic        taken8, taken4;
   int          passed, total;

   x2050psw_store_if bus8 ();
   x2050psw_store_if bus4 ();

   assign bus8.i_ros_advance = adv;
   assign bus8.i_start       = start8;
   assign bus8.i_abort       = abort8;
   assign bus4.i_ros_advance = adv;
   assign bus4.i_start       = start4;
   assign bus4.i_abort       = abort4;

   x2050psw_store #(.NBYTES(8)) dut8 (
      .i_clk(clk), .i_reset(rst), .bus(bus8),
      .i_cc_reg(cc), .i_progmask(pm), .i_ilc(ilc),
      .i_sysmask(sysmask), .i_key(key), .i_amwp(amwp),
      .i_intcode(intcode), .i_ia(ia), .i_bc_mask(bcm),
      .o_bc_taken(taken8)
   );

   x2050psw_store #(.NBYTES(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .bus(bus4),
      .i_cc_reg(cc), .i_progmask(pm), .i_ilc(ilc),
      .i_sysmask(sysmask), .i_key(key), .i_amwp(amwp),
      .i_intcode(intcode), .i_ia(ia), .i_bc_mask(bcm),
      .o_bc_taken(taken4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      total++;
      if ({bus8.o_byte, bus8.o_byte_idx} !== 11'd0)
         $display("FAIL reset_byte: got %h/%0d want 00/0",
                  bus8.o_byte, bus8.o_byte_idx);
      else passed++;
      total++;
      if ({bus8.o_valid, bus8.o_busy, bus8.o_done} !== 3'b000)
         $display("FAIL reset_flags8: got %b want 000",
                  {bus8.o_valid, bus8.o_busy, bus8.o_done});
      else passed++;
      total++;
      if ({bus4.o_valid, bus4.o_busy, bus4.o_done} !== 3'b000)
         $display("FAIL reset_flags4: got %b want 000",
                  {bus4.o_valid, bus4.o_busy, bus4.o_done});
      else passed++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_stream();
      logic [7:0] exp [8];
      int         dones;
      exp = '{8'hFF, 8'h53, 8'h00, 8'h44, 8'h9A, 8'h01, 8'h23, 8'h45};
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         total++;
         if ({bus8.o_valid, bus8.o_busy, bus8.o_done,
              bus8.o_byte_idx, bus8.o_byte} !==
             {3'b110, 3'(i), exp[i]})
            $display("FAIL stream_b%0d: got v%b b%b d%b %0d/%h want 110 %0d/%h",
                     i, bus8.o_valid, bus8.o_busy, bus8.o_done,
                     bus8.o_byte_idx, bus8.o_byte, i, exp[i]);
         else passed++;
      end
      tick();
      dones = int'(bus8.o_done);
      total++;
      if ({bus8.o_valid, bus8.o_busy, bus8.o_done} !== 3'b011)
         $display("FAIL stream_done: got vbd=%b want 011",
                  {bus8.o_valid, bus8.o_busy, bus8.o_done});
      else passed++;
      tick();
      dones += int'(bus8.o_done);
      total++;
      if ({bus8.o_valid, bus8.o_busy, bus8.o_done} !== 3'b000)
         $display("FAIL stream_idle: got vbd=%b want 000",
                  {bus8.o_valid, bus8.o_busy, bus8.o_done});
      else passed++;
      tick();
      dones += int'(bus8.o_done);
      total++;
      if (dones !== 1)
         $display("FAIL stream_done_count: got %0d want 1", dones);
      else passed++;
   endtask

   task automatic test_snapshot();
      cc = 2'd2;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      cc = 2'd3;
      bcm = 4'b0001;
      #1;
      total++;
      if (taken8 !== 1'b1)
         $display("FAIL snap_bc_live: got %b want 1", taken8);
      else passed++;
      repeat (3) tick();
      total++;
      if ({bus8.o_byte_idx, bus8.o_byte} !== {3'd4, 8'hAA})
         $display("FAIL snap_byte4: got %0d/%h want 4/aa",
                  bus8.o_byte_idx, bus8.o_byte);
      else passed++;
      repeat (5) tick();
      cc = 2'd1;
      total++;
      if (bus8.o_busy !== 1'b0)
         $display("FAIL snap_end_busy: got %b want 0", bus8.o_busy);
      else passed++;
   endtask

   task automatic test_gating();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (4) tick();
      adv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({bus8.o_valid, bus8.o_busy, bus8.o_byte_idx, bus8.o_byte}
             !== {2'b11, 3'd4, 8'h9A})
            $display("FAIL gate_hold%0d: got v%b b%b %0d/%h want 11 4/9a",
                     i, bus8.o_valid, bus8.o_busy,
                     bus8.o_byte_idx, bus8.o_byte);
         else passed++;
      end
      adv = 1'b1;
      tick();
      total++;
      if ({bus8.o_byte_idx, bus8.o_byte} !== {3'd5, 8'h01})
         $display("FAIL gate_resume: got %0d/%h want 5/01",
                  bus8.o_byte_idx, bus8.o_byte);
      else passed++;
      repeat (4) tick();
   endtask

   task automatic test_abort();
      int dones;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (6) tick();
      total++;
      if ({bus8.o_byte_idx, bus8.o_byte} !== {3'd6, 8'h23})
         $display("FAIL abort_pre: got %0d/%h want 6/23",
                  bus8.o_byte_idx, bus8.o_byte);
      else passed++;
      abort8 = 1'b1;
      tick();
      abort8 = 1'b0;
      dones = int'(bus8.o_done);
      total++;
      if ({bus8.o_valid, bus8.o_busy} !== 2'b00)
         $display("FAIL abort_flags: got vb=%b want 00",
                  {bus8.o_valid, bus8.o_busy});
      else passed++;
      repeat (3) begin
         tick();
         dones += int'(bus8.o_done);
      end
      total++;
      if (dones !== 0)
         $display("FAIL abort_no_done: got %0d pulses want 0", dones);
      else passed++;
      start8 = 1'b1;
      abort8 = 1'b1;
      tick();
      start8 = 1'b0;
      abort8 = 1'b0;
      total++;
      if ({bus8.o_valid, bus8.o_busy} !== 2'b00)
         $display("FAIL abort_start_idle: got vb=%b want 00",
                  {bus8.o_valid, bus8.o_busy});
      else passed++;
      tick();
      total++;
      if (bus8.o_busy !== 1'b0)
         $display("FAIL abort_stay_idle: got %b want 0", bus8.o_busy);
      else passed++;
   endtask

   task automatic test_reset_mid();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (3) tick();
      total++;
      if ({bus8.o_byte_idx, bus8.o_byte} !== {3'd3, 8'h44})
         $display("FAIL rmid_pre: got %0d/%h want 3/44",
                  bus8.o_byte_idx, bus8.o_byte);
      else passed++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({bus8.o_valid, bus8.o_busy, bus8.o_done, bus8.o_byte_idx}
          !== 6'd0)
         $display("FAIL rmid_clear: got vbd=%b idx=%0d want 000 0",
                  {bus8.o_valid, bus8.o_busy, bus8.o_done},
                  bus8.o_byte_idx);
      else passed++;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      total++;
      if ({bus8.o_valid, bus8.o_byte_idx, bus8.o_byte}
          !== {1'b1, 3'd0, 8'hFF})
         $display("FAIL rmid_restart: got v%b %0d/%h want 1 0/ff",
                  bus8.o_valid, bus8.o_byte_idx, bus8.o_byte);
      else passed++;
      repeat (9) tick();
   endtask

   task automatic test_back_to_back();
      start8 = 1'b1;
      repeat (8) tick();
      total++;
      if ({bus8.o_byte_idx, bus8.o_byte} !== {3'd7, 8'h45})
         $display("FAIL b2b_ignore_start: got %0d/%h want 7/45",
                  bus8.o_byte_idx, bus8.o_byte);
      else passed++;
      tick();
      total++;
      if (bus8.o_done !== 1'b1)
         $display("FAIL b2b_done: got %b want 1", bus8.o_done);
      else passed++;
      tick();
      total++;
      if ({bus8.o_valid, bus8.o_busy} !== 2'b00)
         $display("FAIL b2b_done_ignores_start: got vb=%b want 00",
                  {bus8.o_valid, bus8.o_busy});
      else passed++;
      tick();
      start8 = 1'b0;
      total++;
      if ({bus8.o_valid, bus8.o_busy, bus8.o_byte_idx, bus8.o_byte}
          !== {2'b11, 3'd0, 8'hFF})
         $display("FAIL b2b_restart: got v%b b%b %0d/%h want 11 0/ff",
                  bus8.o_valid, bus8.o_busy,
                  bus8.o_byte_idx, bus8.o_byte);
      else passed++;
      abort8 = 1'b1;
      tick();
      abort8 = 1'b0;
   endtask

   task automatic test_nbytes4();
      logic [7:0] exp [4];
      exp = '{8'hFF, 8'h53, 8'h00, 8'h44};
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         total++;
         if ({bus4.o_valid, bus4.o_byte_idx, bus4.o_byte}
             !== {1'b1, 3'(i), exp[i]})
            $display("FAIL nb4_b%0d: got v%b %0d/%h want 1 %0d/%h",
                     i, bus4.o_valid, bus4.o_byte_idx, bus4.o_byte,
                     i, exp[i]);
         else passed++;
      end
      tick();
      total++;
      if ({bus4.o_valid, bus4.o_busy, bus4.o_done} !== 3'b011)
         $display("FAIL nb4_done: got vbd=%b want 011",
                  {bus4.o_valid, bus4.o_busy, bus4.o_done});
      else passed++;
      tick();
      total++;
      if ({bus4.o_busy, bus4.o_done} !== 2'b00)
         $display("FAIL nb4_idle: got bd=%b want 00",
                  {bus4.o_busy, bus4.o_done});
      else passed++;
   endtask

   task automatic test_bc();
      logic exp;
      for (int c = 0; c < 4; c++) begin
         cc = 2'(c);
         for (int m = 0; m < 4; m++) begin
            bcm = 4'b1000 >> m;
            exp = (m == c);
            #1;
            total++;
            if (taken8 !== exp)
               $display("FAIL bc_cc%0d_m%b: got %b want %b",
                        c, bcm, taken8, exp);
            else passed++;
         end
         bcm = 4'b1111;
         #1;
         total++;
         if (taken4 !== 1'b1)
            $display("FAIL bc_all_cc%0d: got %b want 1", c, taken4);
         else passed++;
         bcm = 4'b0000;
         #1;
         total++;
         if (taken8 !== 1'b0)
            $display("FAIL bc_none_cc%0d: got %b want 0", c, taken8);
         else passed++;
      end
      cc = 2'd1;
   endtask

   initial begin
      passed  = 0;
      total   = 0;
      rst     = 1'b1;
      adv     = 1'b1;
      start8  = 1'b0;
      abort8  = 1'b0;
      start4  = 1'b0;
      abort4  = 1'b0;
      ilc     = 2'd2;
      cc      = 2'd1;
      pm      = 4'hA;
      ia      = 24'h012345;
      sysmask = 8'hFF;
      key     = 4'h5;
      amwp    = 4'h3;
      intcode = 16'h0044;
      bcm     = 4'b0000;
      test_reset();
      test_stream();
      test_snapshot();
      test_gating();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_nbytes4();
      test_bc();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
